reg_writeback_unit: RTL

- Write side of the register memory section. Accepts completed results from the execute/memory stages over a valid/ready channel and buffers them in a small FIFO.
- Drains one register write per cycle into the register file write port. A lo/hi result pair is split into two sequential writes.
- Issues a busy-state decrement for general registers 1..29 in the same cycle as the write, releasing the scoreboard entry that the fetch unit incremented.

---
 rtl/wb_pkg.sv | 36 +++
 rtl/reg_writeback_unit_if.sv | 22 ++
 rtl/wb_fifo.sv | 47 ++++
 rtl/reg_writeback_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register write-back path.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_REG_AW = 5;

   typedef enum logic [1:0] {
      WB_NONE    = 2'b00,
      WB_SINGLE  = 2'b01,
      WB_PAIR    = 2'b10,
      WB_ILLEGAL = 2'b11
   } wb_kind_t;

   localparam logic [WB_REG_AW-1:0] REG_ZERO = 5'd0;
   localparam logic [WB_REG_AW-1:0] REG_LO   = 5'd30;
   localparam logic [WB_REG_AW-1:0] REG_HI   = 5'd31;
   localparam int                   NUM_GPR  = 29;

   typedef struct packed {
      wb_kind_t               kind;
      logic [WB_REG_AW-1:0]   dest;
      logic [WB_DATA_W-1:0]   data;
      logic [WB_DATA_W-1:0]   data_hi;
   } wb_entry_t;

   typedef enum logic {
      WB_IDLE,
      WB_HI
   } wb_state_t;

   // Only general registers carry a busy count in the fetch scoreboard.
   function automatic logic is_gpr(input logic [WB_REG_AW-1:0] r);
      return (r != REG_ZERO) && (int'(r) <= NUM_GPR);
   endfunction

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Result channel from the execute/memory stages into the write-back unit.
interface reg_writeback_unit_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_kind;
   logic [REG_AW-1:0] in_dest;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] in_data_hi;

   modport master (
      output in_valid, in_kind, in_dest, in_data, in_data_hi,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_kind, in_dest, in_data, in_data_hi,
      output in_ready
   );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; pointers carry one extra wrap bit.
module wb_fifo
   import wb_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  wb_entry_t  din_i,
   input  logic       pop_i,
   output wb_entry_t  dout_o,
   output logic       full_o,
   output logic       empty_o,
   output logic [PW:0] count_o
);

   wb_entry_t   mem_q [DEPTH];
   logic [PW:0] wptr_q, rptr_q;
   logic        do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
   assign count_o = wptr_q - rptr_q;
   assign dout_o  = mem_q[rptr_q[PW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // NOTE: storage has no reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[PW-1:0]] <= din_i;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/reg_writeback_unit.sv
// Drains buffered results into the register file, splitting lo/hi pairs and
// releasing scoreboard entries for general registers. Widths follow wb_pkg.
module reg_writeback_unit
   import wb_pkg::*;
#(
   parameter  int DATA_W     = WB_DATA_W,
   parameter  int REG_AW     = WB_REG_AW,
   parameter  int FIFO_DEPTH = 4,
   localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   reg_writeback_unit_if.slave  in_if,
   output logic                 wr_en,
   output logic [REG_AW-1:0]    wr_num,
   output logic [DATA_W-1:0]    wr_data,
   output logic                 state_dec,
   output logic [CW-1:0]        pending,
   output logic                 err
);

   wb_entry_t   push_entry, head;
   logic        full, empty, push, pop;
   wb_state_t   state_q, state_d;
   logic        wr_en_q, wr_en_d, state_dec_q, state_dec_d, err_q, err_d;
   logic [REG_AW-1:0] wr_num_q, wr_num_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   assign push_entry = '{kind:    wb_kind_t'(in_if.in_kind),
                         dest:    in_if.in_dest,
                         data:    in_if.in_data,
                         data_hi: in_if.in_data_hi};

   // Ready depends only on stored occupancy, so a full FIFO never passes through.
   assign in_if.in_ready = !full;
   assign push           = in_if.in_valid && !full;

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   (push_entry),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (pending)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      wr_en_d     = 1'b0;
      state_dec_d = 1'b0;
      wr_num_d    = wr_num_q;
      wr_data_d   = wr_data_q;
      err_d       = err_q;
      case (state_q)
         WB_IDLE: begin
            if (!empty) begin
               case (head.kind)
                  WB_SINGLE: begin
                     pop = 1'b1;
                     if (head.dest != REG_ZERO) begin
                        wr_en_d     = 1'b1;
                        wr_num_d    = head.dest;
                        wr_data_d   = head.data;
                        state_dec_d = is_gpr(head.dest);
                     end
                  end
                  // The pair stays queued until its hi half is written.
                  WB_PAIR: begin
                     wr_en_d   = 1'b1;
                     wr_num_d  = REG_LO;
                     wr_data_d = head.data;
                     state_d   = WB_HI;
                  end
                  WB_ILLEGAL: begin
                     pop   = 1'b1;
                     err_d = 1'b1;
                  end
                  default: pop = 1'b1;
               endcase
            end
         end
         WB_HI: begin
            pop       = 1'b1;
            wr_en_d   = 1'b1;
            wr_num_d  = REG_HI;
            wr_data_d = head.data_hi;
            state_d   = WB_IDLE;
         end
         default: state_d = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= WB_IDLE;
         wr_en_q     <= 1'b0;
         wr_num_q    <= '0;
         wr_data_q   <= '0;
         state_dec_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_en_q     <= wr_en_d;
         wr_num_q    <= wr_num_d;
         wr_data_q   <= wr_data_d;
         state_dec_q <= state_dec_d;
         err_q       <= err_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_num    = wr_num_q;
   assign wr_data   = wr_data_q;
   assign state_dec = state_dec_q;
   assign err       = err_q;

endmodule
